// File: rtl/i2c_pwm_controller.sv
// i2c_pwm_controller: eight-channel LED PWM with I2C-accessible duty registers and a heartbeat LED
// Ports: clk system clock; rst_n asynchronous active-low reset; scl/sda I2C slave port
//        (sda open-drain, only ever pulled low); led heartbeat; leds[7:0] PWM outputs, bit n = channel n.
module i2c_pwm_controller #(
   parameter logic [6:0]  I2C_ADDR      = 7'h42,
   parameter int unsigned PWM_DIV       = 1200,
   parameter int unsigned HEARTBEAT_DIV = 12000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       scl,
   inout  wire        sda,
   output logic       led,
   output logic [7:0] leds
);
   typedef enum logic [3:0] {IDLE, ADDR, ACK_ADDR, PTR, ACK_PTR, WDATA, ACK_W, RDATA, MACK} state_t;
   localparam logic [7:0] RST_VAL [8] = '{8'd1, 8'd20, 8'd40, 8'd60, 8'd80, 8'd100, 8'd200, 8'd255};
   state_t      state_q, state_d;
   logic [4:0]  scl_p_q, scl_p_d, sda_p_q, sda_p_d;
   logic        scl_f_q, sda_f_q, scl_f, sda_f;
   logic        scl_rise, scl_fall, start, stop, addr_hit, rd_load;
   logic [3:0]  bit_q, bit_d;
   logic [7:0]  sh_q, sh_d;
   logic [2:0]  ptr_q, ptr_d;
   logic        oe_q, oe_d;
   logic [7:0]  val_q [8], val_d [8], act_q [8], act_d [8];
   logic [31:0] pre_q, pre_d, hb_q, hb_d;
   logic [7:0]  cnt_q, cnt_d, leds_q, leds_d;
   logic        led_q, led_d, tick, wrap, hb_wrap;

   function automatic logic maj3(input logic [2:0] v);
      return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
   endfunction

   // bits [1:0] are the synchronizer, bits [4:2] the three debounce samples
   assign scl_f    = maj3(scl_p_q[4:2]);
   assign sda_f    = maj3(sda_p_q[4:2]);
   assign scl_rise = scl_f & ~scl_f_q;
   assign scl_fall = ~scl_f & scl_f_q;
   assign start    = scl_f & scl_f_q & sda_f_q & ~sda_f;
   assign stop     = scl_f & scl_f_q & ~sda_f_q & sda_f;
   assign addr_hit = sh_q[7:1] == I2C_ADDR;
   assign sda      = oe_q ? 1'b0 : 1'bz;
   assign led      = led_q;
   assign leds     = leds_q;

   always_comb begin
      scl_p_d = {scl_p_q[3:0], scl};
      sda_p_d = {sda_p_q[3:0], sda};
      state_d = state_q;
      bit_d   = bit_q;
      sh_d    = sh_q;
      ptr_d   = ptr_q;
      oe_d    = oe_q;
      val_d   = val_q;
      rd_load = 1'b0;
      if (start) begin
         state_d = ADDR;
         bit_d   = '0;
         oe_d    = 1'b0;
      end else if (stop) begin
         state_d = IDLE;
         oe_d    = 1'b0;
      end else if (scl_rise) begin
         if (state_q inside {ADDR, PTR, WDATA, RDATA}) begin
            sh_d  = {sh_q[6:0], sda_f};
            bit_d = bit_q + 4'd1;
         end
         // the write commits on the 8th rising edge, before the ACK bit
         if (state_q == WDATA && bit_q == 4'd7) begin
            val_d[ptr_q] = {sh_q[6:0], sda_f};
            ptr_d        = ptr_q + 3'd1;
         end
         // bit count 9 marks a master ACK so the next falling edge reloads
         if (state_q == MACK) begin
            state_d = sda_f ? IDLE : MACK;
            ptr_d   = sda_f ? ptr_q : ptr_q + 3'd1;
            bit_d   = 4'd9;
         end
      end else if (scl_fall) begin
         case (state_q)
            ADDR: if (bit_q == 4'd8) begin
               state_d = addr_hit ? ACK_ADDR : IDLE;
               oe_d    = addr_hit;
            end
            ACK_ADDR: if (sh_q[0]) rd_load = 1'b1;
            else begin
               state_d = PTR;
               bit_d   = '0;
               oe_d    = 1'b0;
            end
            PTR: if (bit_q == 4'd8) begin
               ptr_d   = sh_q[2:0];
               state_d = ACK_PTR;
               oe_d    = 1'b1;
            end
            WDATA: if (bit_q == 4'd8) begin
               state_d = ACK_W;
               oe_d    = 1'b1;
            end
            ACK_PTR, ACK_W: begin
               state_d = WDATA;
               bit_d   = '0;
               oe_d    = 1'b0;
            end
            RDATA: begin
               state_d = (bit_q == 4'd8) ? MACK : RDATA;
               oe_d    = (bit_q != 4'd8) & ~sh_q[7];
            end
            MACK: rd_load = bit_q == 4'd9;
            default: ;
         endcase
      end
      if (rd_load) begin
         state_d = RDATA;
         bit_d   = '0;
         sh_d    = val_q[ptr_q];
         oe_d    = ~val_q[ptr_q][7];
      end
   end

   always_comb begin
      tick    = pre_q == PWM_DIV - 1;
      pre_d   = tick ? '0 : pre_q + 32'd1;
      wrap    = tick && cnt_q == 8'd254;
      cnt_d   = wrap ? 8'd0 : cnt_q + {7'd0, tick};
      act_d   = wrap ? val_q : act_q;
      hb_wrap = hb_q == HEARTBEAT_DIV - 1;
      hb_d    = hb_wrap ? '0 : hb_q + 32'd1;
      led_d   = led_q ^ hb_wrap;
      leds_d  = '0;
      for (int i = 0; i < 8; i++) leds_d[i] = cnt_q < act_q[i];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         scl_p_q <= '1;
         sda_p_q <= '1;
         scl_f_q <= 1'b1;
         sda_f_q <= 1'b1;
         bit_q   <= '0;
         sh_q    <= '0;
         ptr_q   <= '0;
         oe_q    <= 1'b0;
         pre_q   <= '0;
         hb_q    <= '0;
         cnt_q   <= '0;
         leds_q  <= '0;
         led_q   <= 1'b0;
         for (int i = 0; i < 8; i++) begin
            val_q[i] <= RST_VAL[i];
            act_q[i] <= RST_VAL[i];
         end
      end else begin
         state_q <= state_d;
         scl_p_q <= scl_p_d;
         sda_p_q <= sda_p_d;
         scl_f_q <= scl_f;
         sda_f_q <= sda_f;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         ptr_q   <= ptr_d;
         oe_q    <= oe_d;
         pre_q   <= pre_d;
         hb_q    <= hb_d;
         cnt_q   <= cnt_d;
         leds_q  <= leds_d;
         led_q   <= led_d;
         val_q   <= val_d;
         act_q   <= act_d;
      end
   end
endmodule

// File: tb/tb_i2c_pwm_controller.sv
// tb_i2c_pwm_controller: directed bench driving a bit-banged I2C master against the PWM controller
module tb_i2c_pwm_controller;
   localparam int Q = 20;
   logic       clk = 1'b0, rst_n = 1'b0, scl = 1'b1, sda_m = 1'b1, led;
   logic [7:0] leds;
   wire        sda;
   int         checks = 0, failures = 0;
   int         hi [8];
   logic       drv_mon = 1'b0, drv_seen = 1'b0;

   assign sda = sda_m ? 1'bz : 1'b0;
   pullup (sda);
   always #5 clk = ~clk;

   i2c_pwm_controller #(.I2C_ADDR(7'h42), .PWM_DIV(1), .HEARTBEAT_DIV(10)) dut (
      .clk(clk), .rst_n(rst_n), .scl(scl), .sda(sda), .led(led), .leds(leds)
   );

   always @(posedge clk) if (drv_mon && sda_m && sda === 1'b0) drv_seen <= 1'b1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic q();
      repeat (Q) @(posedge clk);
      #1;
   endtask

   task automatic i2c_start();
      sda_m = 1'b1; q(); scl = 1'b1; q(); sda_m = 1'b0; q(); scl = 1'b0; q();
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; q(); scl = 1'b1; q(); sda_m = 1'b1; q();
   endtask

   task automatic i2c_bit(input logic b, output logic r);
      sda_m = b; q(); scl = 1'b1; q(); r = sda; q(); scl = 1'b0; q();
   endtask

   task automatic i2c_wr(input logic [7:0] d, output logic a);
      logic r;
      for (int i = 7; i >= 0; i--) i2c_bit(d[i], r);
      i2c_bit(1'b1, a);
   endtask

   task automatic i2c_rd(input logic m_ack, output logic [7:0] d);
      logic r;
      for (int i = 7; i >= 0; i--) i2c_bit(1'b1, d[i]);
      i2c_bit(m_ack, r);
   endtask

   task automatic measure();
      hi = '{default: 0};
      repeat (255) begin
         @(negedge clk);
         for (int n = 0; n < 8; n++) hi[n] += int'(leds[n]);
      end
   endtask

   initial begin
      logic       a;
      logic [7:0] rb;
      repeat (3) @(posedge clk);
      #1;
      check("rst_led", led, 0);
      check("rst_leds", leds, 0);
      check("rst_sda", sda, 1);
      @(negedge clk) rst_n = 1'b1;
      repeat (9) @(posedge clk);
      #1 check("hb_clk9", led, 0);
      @(posedge clk);
      #1 check("hb_clk10", led, 1);
      repeat (10) @(posedge clk);
      #1 check("hb_clk20", led, 0);
      measure();
      check("def_ch0", hi[0], 1);
      check("def_ch3", hi[3], 60);
      check("def_ch6", hi[6], 200);
      check("def_ch7", hi[7], 255);
      // write with auto-increment and pointer wrap 7 -> 0
      i2c_start();
      i2c_wr(8'h84, a); check("w_addr_ack", a, 0);
      i2c_wr(8'h06, a); check("w_ptr_ack", a, 0);
      i2c_wr(8'h00, a); check("w_d0_ack", a, 0);
      i2c_wr(8'h80, a); check("w_d1_ack", a, 0);
      i2c_wr(8'h7F, a); check("w_d2_ack", a, 0);
      i2c_stop();
      repeat (300) @(posedge clk);
      measure();
      check("w_ch6", hi[6], 0);
      check("w_ch7", hi[7], 128);
      check("w_ch0", hi[0], 127);
      check("w_ch5", hi[5], 100);
      // pointer write, repeated start, two-byte read
      i2c_start();
      i2c_wr(8'h84, a); check("r_waddr_ack", a, 0);
      i2c_wr(8'h03, a); check("r_ptr_ack", a, 0);
      i2c_start();
      i2c_wr(8'h85, a); check("r_raddr_ack", a, 0);
      i2c_rd(1'b0, rb); check("r_byte0", rb, 60);
      i2c_rd(1'b1, rb); check("r_byte1", rb, 80);
      check("r_sda_released", sda, 1);
      i2c_stop();
      // foreign address must never be acknowledged
      drv_mon = 1'b1;
      i2c_start();
      i2c_wr(8'h90, a); check("mm_addr_nack", a, 1);
      i2c_wr(8'hA5, a); check("mm_data_nack", a, 1);
      i2c_stop();
      drv_mon = 1'b0;
      check("mm_no_drive", drv_seen, 0);
      // STOP inside a data byte writes nothing
      i2c_start();
      i2c_wr(8'h84, a);
      i2c_wr(8'h01, a);
      for (int i = 0; i < 4; i++) i2c_bit(1'b1, a);
      i2c_stop();
      i2c_start();
      i2c_wr(8'h84, a);
      i2c_wr(8'h01, a);
      i2c_start();
      i2c_wr(8'h85, a);
      i2c_rd(1'b1, rb); check("abort_val1", rb, 20);
      i2c_stop();
      // reset during a read releases sda at once and restores duties
      i2c_start();
      i2c_wr(8'h84, a);
      i2c_wr(8'h01, a);
      i2c_wr(8'h55, a); check("rst_w_ack", a, 0);
      i2c_stop();
      i2c_start();
      i2c_wr(8'h84, a);
      i2c_wr(8'h01, a);
      i2c_start();
      i2c_wr(8'h85, a);
      check("rd_drive_low", sda, 0);
      rst_n = 1'b0;
      #1 check("rst_sda_async", sda, 1);
      @(negedge clk) rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      i2c_start();
      i2c_wr(8'h84, a);
      i2c_wr(8'h01, a);
      i2c_start();
      i2c_wr(8'h85, a);
      i2c_rd(1'b1, rb); check("rst_val1", rb, 20);
      i2c_stop();
      measure();
      check("rst_ch1", hi[1], 20);
      check("rst_ch0", hi[0], 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
